result_writer: RTL and testbench

Downstream stage of the array results controller. Captures the tile-row beats it emits on its unthrottled valid/data bus into a small FIFO. Computes the row-major destination address of each beat in the C matrix (m x p) and issues them as memory writes over a valid/ready interface. Pulses `done` after the last beat of the product is accepted by memory.

---
 rtl/result_writer.sv | 194 +++++++++++++++++++
 tb/tb_result_writer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_writer.sv
// Beat FIFO: stores result beats in order; the head is a registered entry.
// Latency: a beat written at edge t is at dat_o in cycle t+1.
// Backpressure: none inside; the caller pushes only when not full or when popping in the same cycle.
module rw_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       dat_i,
    output logic [WIDTH-1:0]       dat_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [PW:0]      count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= dat_i;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop_i) rd_q <= rd_q + PW'(1);
            if (push_i && !pop_i)      count_q <= count_q + (PW+1)'(1);
            else if (!push_i && pop_i) count_q <= count_q - (PW+1)'(1);
        end
    end

    assign dat_o   = mem_q[rd_q];
    assign count_o = count_q;
endmodule

// Result writer: buffers tile-row beats and writes them row-major into C (m x p).
// Latency: a captured beat is offered to memory the next cycle; 1 beat/cycle sustained.
// Backpressure: mem_ready stalls the FIFO head; upstream cannot stall, so excess beats are dropped and flagged.
module result_writer #(
    parameter int ARRAY_HEIGHT = 4,
    parameter int ARRAY_WIDTH  = 32,
    parameter int DATA_WIDTH   = 16,
    parameter int BUS_WIDTH    = 256,
    parameter int ADDR_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [15:0]           m,
    input  logic [15:0]           p,
    input  logic [BUS_WIDTH-1:0]  data_i,
    input  logic                  valid_i,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BUS_WIDTH-1:0]  mem_data,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  done,
    output logic                  overflow
);
    localparam int E     = BUS_WIDTH / DATA_WIDTH;
    localparam int BEATS = ARRAY_WIDTH * DATA_WIDTH / BUS_WIDTH;
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RW    = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
    localparam logic [ADDR_WIDTH-1:0] BEAT_STRIDE = ADDR_WIDTH'(E * BYTES);
    localparam logic [ADDR_WIDTH-1:0] TILE_STRIDE = ADDR_WIDTH'(ARRAY_WIDTH * BYTES);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count;
    logic            push, pop, start_acc, last_beat;
    logic            last_b, last_r, last_tc, last_tr;
    logic            overflow_q, overflow_d;
    logic [BW-1:0]   b_q, b_d;
    logic [RW-1:0]   r_q, r_d;
    logic [16:0]     tc_q, tc_d, tr_q, tr_d, m_q, m_d, p_q, p_d;
    logic [ADDR_WIDTH-1:0] p_stride_q, p_stride_d, hp_stride_q, hp_stride_d;
    logic [ADDR_WIDTH-1:0] trow_q, trow_d, tile_q, tile_d, row_q, row_d, addr_q, addr_d;

    rw_fifo #(.WIDTH(BUS_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .dat_i   (data_i),
        .dat_o   (mem_data),
        .count_o (count)
    );

    assign start_acc = start && (state_q == S_IDLE);
    assign pop       = mem_valid && mem_ready;
    assign push      = valid_i && (state_q == S_RUN) && ((count < CW'(FIFO_DEPTH)) || pop);

    assign last_b    = (b_q == BW'(BEATS - 1));
    assign last_r    = (r_q == RW'(ARRAY_HEIGHT - 1));
    assign last_tc   = ((tc_q + 17'(ARRAY_WIDTH)) >= p_q);
    assign last_tr   = ((tr_q + 17'(ARRAY_HEIGHT)) >= m_q);
    assign last_beat = last_b && last_r && last_tc && last_tr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (pop && last_beat) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        done      = (state_q == S_DONE);
        mem_valid = (state_q == S_RUN) && (count != '0);
    end

    // Address walk: each accumulator holds the byte address of its loop level's origin,
    // so a pop only ever adds a precomputed stride.
    always_comb begin
        b_d = b_q;  r_d = r_q;  tc_d = tc_q;  tr_d = tr_q;
        m_d = m_q;  p_d = p_q;
        p_stride_d = p_stride_q;  hp_stride_d = hp_stride_q;
        trow_d = trow_q;  tile_d = tile_q;  row_d = row_q;  addr_d = addr_q;
        overflow_d = overflow_q | (valid_i & ~push);
        if (start_acc) begin
            b_d = '0;  r_d = '0;  tc_d = '0;  tr_d = '0;
            m_d = {1'b0, m};  p_d = {1'b0, p};
            p_stride_d  = ADDR_WIDTH'(p) * ADDR_WIDTH'(BYTES);
            hp_stride_d = ADDR_WIDTH'(p) * ADDR_WIDTH'(BYTES * ARRAY_HEIGHT);
            trow_d = base_addr;  tile_d = base_addr;  row_d = base_addr;  addr_d = base_addr;
        end else if (pop) begin
            if (!last_b) begin
                b_d    = b_q + BW'(1);
                addr_d = addr_q + BEAT_STRIDE;
            end else begin
                b_d = '0;
                if (!last_r) begin
                    r_d    = r_q + RW'(1);
                    row_d  = row_q + p_stride_q;
                    addr_d = row_q + p_stride_q;
                end else begin
                    r_d = '0;
                    if (!last_tc) begin
                        tc_d   = tc_q + 17'(ARRAY_WIDTH);
                        tile_d = tile_q + TILE_STRIDE;
                        row_d  = tile_q + TILE_STRIDE;
                        addr_d = tile_q + TILE_STRIDE;
                    end else begin
                        tc_d   = '0;
                        tr_d   = tr_q + 17'(ARRAY_HEIGHT);
                        trow_d = trow_q + hp_stride_q;
                        tile_d = trow_q + hp_stride_q;
                        row_d  = trow_q + hp_stride_q;
                        addr_d = trow_q + hp_stride_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b_q <= '0;  r_q <= '0;  tc_q <= '0;  tr_q <= '0;
            m_q <= '0;  p_q <= '0;
            p_stride_q <= '0;  hp_stride_q <= '0;
            trow_q <= '0;  tile_q <= '0;  row_q <= '0;  addr_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            b_q <= b_d;  r_q <= r_d;  tc_q <= tc_d;  tr_q <= tr_d;
            m_q <= m_d;  p_q <= p_d;
            p_stride_q <= p_stride_d;  hp_stride_q <= hp_stride_d;
            trow_q <= trow_d;  tile_q <= tile_d;  row_q <= row_d;  addr_q <= addr_d;
            overflow_q <= overflow_d;
        end
    end

    assign mem_addr = addr_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_result_writer.sv
// Directed bench for result_writer with H=2, W=4, 16-bit elements on a 32-bit bus, 4-deep FIFO.
module tb_result_writer;
    localparam int H = 2, W = 4, DW = 16, BW = 32, AW = 32, FD = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [15:0]   m = '0;
    logic [15:0]   p = '0;
    logic [BW-1:0] data_i = '0;
    logic          valid_i = 1'b0;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_data;
    logic          mem_valid, done, overflow;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int hs_at_done = -1;
    logic [AW-1:0] got_a [$];
    logic [BW-1:0] got_d [$];

    logic [AW-1:0] basic_a [16] = '{32'h1000, 32'h1004, 32'h1010, 32'h1014,
                                    32'h1008, 32'h100C, 32'h1018, 32'h101C,
                                    32'h1020, 32'h1024, 32'h1030, 32'h1034,
                                    32'h1028, 32'h102C, 32'h1038, 32'h103C};
    logic [AW-1:0] ovf_a [4]   = '{32'h2000, 32'h2004, 32'h2010, 32'h2014};
    logic [AW-1:0] wrap_a [4]  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    result_writer #(
        .ARRAY_HEIGHT(H), .ARRAY_WIDTH(W), .DATA_WIDTH(DW),
        .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .m(m), .p(p), .data_i(data_i), .valid_i(valid_i),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input int k, input logic [7:0] salt);
        return {salt, 8'(k), 16'hBEEF ^ 16'(k)};
    endfunction

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, log the handshake that the coming edge completes, sample 1 time unit after it.
    task automatic step(input logic vld, input logic [31:0] dt, input logic rdy);
        valid_i   = vld;
        data_i    = dt;
        mem_ready = rdy;
        if (mem_valid && rdy) begin
            got_a.push_back(mem_addr);
            got_d.push_back(mem_data);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
                done_cyc   = cyc;
                hs_at_done = got_a.size();
            end
        end
        valid_i = 1'b0;
        start   = 1'b0;
    endtask

    task automatic clear_log();
        got_a.delete();
        got_d.delete();
        done_cnt   = 0;
        done_cyc   = -1;
        hs_at_done = -1;
    endtask

    // Job parameters are scrambled right after start; the running job must ignore them.
    task automatic start_job(input logic [31:0] b, input logic [15:0] mm, input logic [15:0] pp);
        base_addr = b;
        m         = mm;
        p         = pp;
        start     = 1'b1;
        step(1'b0, 32'h0, 1'b0);
        base_addr = 32'hDEAD_0000;
        m         = 16'd2;
        p         = 16'd4;
    endtask

    initial begin
        int t0;
        int nb;
        int hs;
        int k;
        logic rdy;
        logic vld;

        #1;
        chk_b("rst_mem_valid", mem_valid, 1'b0);
        chk_b("rst_done", done, 1'b0);
        chk_b("rst_overflow", overflow, 1'b0);
        chk_w("rst_mem_addr", mem_addr, 32'h0);
        chk_w("rst_mem_data", mem_data, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Basic job at full rate.
        clear_log();
        start_job(32'h1000, 16'd4, 16'd8);
        chk_b("basic_idle_head", mem_valid, 1'b0);
        t0 = cyc;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, dat(i, 8'h11), 1'b1);
            if (i == 0) begin
                chk_b("basic_first_vld", mem_valid, 1'b1);
                chk_w("basic_first_addr", mem_addr, 32'h1000);
                chk_w("basic_first_data", mem_data, dat(0, 8'h11));
            end
        end
        for (int i = 0; i < 30 && done_cnt == 0; i++) step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk_i("basic_writes", got_a.size(), 16);
        for (int i = 0; i < 16 && i < got_a.size(); i++) begin
            chk_w($sformatf("basic_addr_%0d", i), got_a[i], basic_a[i]);
            chk_w($sformatf("basic_data_%0d", i), got_d[i], dat(i, 8'h11));
        end
        chk_i("basic_done_count", done_cnt, 1);
        chk_i("basic_done_after_hs", hs_at_done, 16);
        chk_i("basic_done_latency", done_cyc - t0, 17);
        chk_b("basic_overflow", overflow, 1'b0);

        // Backpressure: ready 1-0-0-1, beats every other cycle.
        clear_log();
        start_job(32'h1000, 16'd4, 16'd8);
        nb = 0;
        for (int c = 0; c < 200 && done_cnt == 0; c++) begin
            rdy = ((c % 4) == 0) || ((c % 4) == 3);
            vld = ((c % 2) == 0) && (nb < 16);
            step(vld, dat(nb, 8'h5A), rdy);
            if (vld) nb++;
            if (mem_valid) begin
                hs = got_a.size();
                if (hs < 16) begin
                    chk_w("bp_head_addr", mem_addr, basic_a[hs]);
                    chk_w("bp_head_data", mem_data, dat(hs, 8'h5A));
                end
            end
        end
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk_i("bp_writes", got_a.size(), 16);
        for (int i = 0; i < 16 && i < got_a.size(); i++) begin
            chk_w($sformatf("bp_addr_%0d", i), got_a[i], basic_a[i]);
            chk_w($sformatf("bp_data_%0d", i), got_d[i], dat(i, 8'h5A));
        end
        chk_i("bp_done_count", done_cnt, 1);
        chk_b("bp_overflow", overflow, 1'b0);

        // Full FIFO with push and pop in the same cycle.
        clear_log();
        start_job(32'h2000, 16'd4, 16'd8);
        for (int i = 0; i < 4; i++) step(1'b1, dat(i, 8'h33), 1'b0);
        chk_b("full_no_ovf", overflow, 1'b0);
        step(1'b1, dat(4, 8'h33), 1'b1);
        chk_i("full_pp_hs", got_a.size(), 1);
        chk_b("full_pp_no_ovf", overflow, 1'b0);
        chk_w("full_pp_head_addr", mem_addr, 32'h2004);
        chk_w("full_pp_head_data", mem_data, dat(1, 8'h33));
        step(1'b1, dat(5, 8'h33), 1'b0);
        chk_b("full_count_still_4", overflow, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);
        chk_i("full_drain_writes", got_a.size(), 5);
        if (got_a.size() >= 5) begin
            chk_w("full_pushed_addr", got_a[4], 32'h2008);
            chk_w("full_pushed_data", got_d[4], dat(4, 8'h33));
        end

        reset_n = 1'b0;
        #1;
        chk_b("rst2_overflow_clear", overflow, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Overflow: six beats against a stalled memory.
        clear_log();
        start_job(32'h2000, 16'd4, 16'd8);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, dat(i, 8'h77), 1'b0);
            chk_b($sformatf("ovf_after_beat_%0d", i + 1), overflow, (i >= 4));
        end
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);
        chk_i("ovf_drain_writes", got_a.size(), 4);
        for (int i = 0; i < 4 && i < got_a.size(); i++) begin
            chk_w($sformatf("ovf_addr_%0d", i), got_a[i], ovf_a[i]);
            chk_w($sformatf("ovf_data_%0d", i), got_d[i], dat(i, 8'h77));
        end
        chk_b("ovf_sticky", overflow, 1'b1);
        chk_b("ovf_drained_vld", mem_valid, 1'b0);

        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset in the middle of a job.
        clear_log();
        start_job(32'h3000, 16'd4, 16'd8);
        k = 0;
        for (int i = 0; i < 20 && got_a.size() < 3; i++) begin
            step(1'b1, dat(k, 8'h99), 1'b1);
            k++;
        end
        chk_i("mid_writes_before_rst", got_a.size(), 3);
        reset_n = 1'b0;
        #1;
        chk_b("mid_rst_mem_valid", mem_valid, 1'b0);
        chk_b("mid_rst_done", done, 1'b0);
        chk_b("mid_rst_overflow", overflow, 1'b0);
        chk_w("mid_rst_mem_addr", mem_addr, 32'h0);
        chk_w("mid_rst_mem_data", mem_data, 32'h0);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        reset_n = 1'b1;
        step(1'b0, 32'h0, 1'b1);
        chk_b("mid_after_rst_vld", mem_valid, 1'b0);
        chk_i("mid_no_done", done_cnt, 0);

        // Fresh job from a new base that wraps the address space.
        clear_log();
        start_job(32'hFFFF_FFF8, 16'd2, 16'd4);
        for (int i = 0; i < 4; i++) step(1'b1, dat(i, 8'hE1), 1'b1);
        for (int i = 0; i < 20 && done_cnt == 0; i++) step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk_i("wrap_writes", got_a.size(), 4);
        for (int i = 0; i < 4 && i < got_a.size(); i++) begin
            chk_w($sformatf("wrap_addr_%0d", i), got_a[i], wrap_a[i]);
            chk_w($sformatf("wrap_data_%0d", i), got_d[i], dat(i, 8'hE1));
        end
        chk_i("wrap_done_count", done_cnt, 1);
        chk_i("wrap_done_after_hs", hs_at_done, 4);
        chk_b("wrap_overflow", overflow, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
